// File: rtl/ps2_scancode_decoder_if.sv
// ps2_scancode_decoder_if
// Bundles the decoder's byte-stream input, key-event output and the
// command handshake towards the PS2 port.
//   slave  : the decoder side (consumes bytes/acks, produces events/commands)
//   master : the environment side (PS2 port + event consumer)
interface ps2_scancode_decoder_if;
  logic [7:0] received_data;
  logic       received_data_en;
  logic [7:0] key_code;
  logic       key_extended;
  logic       key_released;
  logic [7:0] key_ascii;
  logic       key_valid;
  logic       key_ready;
  logic       shift_state;
  logic       caps_lock;
  logic       overflow;
  logic [7:0] the_command;
  logic       send_command;
  logic       command_was_sent;
  logic       error_communication_timed_out;
  logic       led_error;

  modport slave (
    input  received_data, received_data_en, key_ready,
           command_was_sent, error_communication_timed_out,
    output key_code, key_extended, key_released, key_ascii, key_valid,
           shift_state, caps_lock, overflow, the_command, send_command,
           led_error
  );

  modport master (
    output received_data, received_data_en, key_ready,
           command_was_sent, error_communication_timed_out,
    input  key_code, key_extended, key_released, key_ascii, key_valid,
           shift_state, caps_lock, overflow, the_command, send_command,
           led_error
  );
endinterface

// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder
// Parses a PS/2 Set-2 byte stream into single key events (make/break,
// extended, ASCII), tracks Shift/Caps Lock, and keeps the keyboard's
// Caps Lock LED in sync via ED <val> command pairs.
// Ports:
//   clk      : system clock
//   reset_n  : synchronous active-low reset
//   bus      : ps2_scancode_decoder_if.slave (byte stream, event, command)
// Parameter:
//   ACK_TIMEOUT : cycles to wait for 0xFA after each command byte
module ps2_scancode_decoder #(
  parameter int ACK_TIMEOUT = 50000
) (
  input logic                   clk,
  input logic                   reset_n,
  ps2_scancode_decoder_if.slave bus
);

  typedef enum logic [2:0] {P_IDLE, P_E0, P_F0, P_E0F0, P_PAUSE} p_state_t;
  typedef enum logic [2:0] {L_IDLE, L_SEND_ED, L_ACK1, L_SEND_VAL, L_ACK2} l_state_t;

  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  p_state_t   p_state, p_next;
  logic [2:0] skip_cnt, cnt_next;
  l_state_t   l_state;
  logic [TW-1:0] timer;

  logic [7:0] key_code, key_ascii, the_command;
  logic       key_extended, key_released, key_valid, overflow;
  logic       shift_l, shift_r, caps_lock, caps_held;
  logic       send_command, led_error, led_pending;

  logic       ev_fire, ev_ext, ev_rel, ack_seen, caps_toggle, shift_state;
  logic [7:0] ev_code, ev_ascii;

  assign shift_state = shift_l | shift_r;

  function automatic logic [7:0] ascii_of(input logic [7:0] c, input logic sh,
                                          input logic cl);
    logic [7:0] l;
    logic [7:0] r;
    l = 8'h00;
    r = 8'h00;
    case (c)
      8'h1C: l = "a"; 8'h32: l = "b"; 8'h21: l = "c"; 8'h23: l = "d";
      8'h24: l = "e"; 8'h2B: l = "f"; 8'h34: l = "g"; 8'h33: l = "h";
      8'h43: l = "i"; 8'h3B: l = "j"; 8'h42: l = "k"; 8'h4B: l = "l";
      8'h3A: l = "m"; 8'h31: l = "n"; 8'h44: l = "o"; 8'h4D: l = "p";
      8'h15: l = "q"; 8'h2D: l = "r"; 8'h1B: l = "s"; 8'h2C: l = "t";
      8'h3C: l = "u"; 8'h2A: l = "v"; 8'h1D: l = "w"; 8'h22: l = "x";
      8'h35: l = "y"; 8'h1A: l = "z";
      default: l = 8'h00;
    endcase
    case (c)
      8'h45: r = sh ? ")" : "0"; 8'h16: r = sh ? "!" : "1";
      8'h1E: r = sh ? "@" : "2"; 8'h26: r = sh ? "#" : "3";
      8'h25: r = sh ? "$" : "4"; 8'h2E: r = sh ? "%" : "5";
      8'h36: r = sh ? "^" : "6"; 8'h3D: r = sh ? "&" : "7";
      8'h3E: r = sh ? "*" : "8"; 8'h46: r = sh ? "(" : "9";
      8'h29: r = 8'h20; 8'h5A: r = 8'h0D; 8'h66: r = 8'h08;
      8'h0D: r = 8'h09; 8'h76: r = 8'h1B;
      default: r = 8'h00;
    endcase
    if (l != 8'h00) r = (sh ^ cl) ? (l - 8'h20) : l;
    return r;
  endfunction

  // Byte classification in the current parse state.
  always_comb begin
    p_next   = p_state;
    cnt_next = skip_cnt;
    ev_fire  = 1'b0;
    ev_ext   = 1'b0;
    ev_rel   = 1'b0;
    ev_code  = bus.received_data;
    ack_seen = 1'b0;
    if (bus.received_data_en) begin
      case (p_state)
        P_IDLE: begin
          case (bus.received_data)
            8'hE0: p_next = P_E0;
            8'hF0: p_next = P_F0;
            8'hE1: begin p_next = P_PAUSE; cnt_next = 3'd7; end
            8'hFA: ack_seen = 1'b1;
            8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF: begin end
            default: ev_fire = 1'b1;
          endcase
        end
        P_E0: begin
          if (bus.received_data == 8'hF0) p_next = P_E0F0;
          else begin
            p_next = P_IDLE;
            if (bus.received_data != 8'h12 && bus.received_data != 8'h59) begin
              ev_fire = 1'b1;
              ev_ext  = 1'b1;
            end
          end
        end
        P_F0: begin
          p_next  = P_IDLE;
          ev_fire = 1'b1;
          ev_rel  = 1'b1;
        end
        P_E0F0: begin
          p_next = P_IDLE;
          if (bus.received_data != 8'h12 && bus.received_data != 8'h59) begin
            ev_fire = 1'b1;
            ev_ext  = 1'b1;
            ev_rel  = 1'b1;
          end
        end
        P_PAUSE: begin
          cnt_next = skip_cnt - 3'd1;
          // The 7 bytes following E1 are swallowed; the last one emits Pause.
          if (skip_cnt <= 3'd1) begin
            p_next   = P_IDLE;
            cnt_next = 3'd0;
            ev_fire  = 1'b1;
            ev_ext   = 1'b1;
            ev_code  = 8'h77;
          end
        end
        default: p_next = P_IDLE;
      endcase
    end
  end

  assign ev_ascii    = ev_ext ? 8'h00 : ascii_of(ev_code, shift_state, caps_lock);
  assign caps_toggle = ev_fire && !ev_ext && !ev_rel && ev_code == 8'h58 && !caps_held;

  // Parser, event register and modifiers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      p_state      <= P_IDLE;
      skip_cnt     <= 3'd0;
      key_code     <= 8'h00;
      key_ascii    <= 8'h00;
      key_extended <= 1'b0;
      key_released <= 1'b0;
      key_valid    <= 1'b0;
      overflow     <= 1'b0;
      shift_l      <= 1'b0;
      shift_r      <= 1'b0;
      caps_lock    <= 1'b0;
      caps_held    <= 1'b0;
    end else begin
      p_state  <= p_next;
      skip_cnt <= cnt_next;
      if (ev_fire) begin
        if (!key_valid || bus.key_ready) begin
          key_code     <= ev_code;
          key_ascii    <= ev_ascii;
          key_extended <= ev_ext;
          key_released <= ev_rel;
          key_valid    <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
        // Modifiers track the keyboard even when the event itself is dropped.
        if (!ev_ext) begin
          if (ev_code == 8'h12) shift_l <= !ev_rel;
          if (ev_code == 8'h59) shift_r <= !ev_rel;
          if (ev_code == 8'h58) begin
            caps_held <= !ev_rel;
            if (caps_toggle) caps_lock <= ~caps_lock;
          end
        end
      end else if (key_valid && bus.key_ready) begin
        key_valid <= 1'b0;
      end
    end
  end

  // LED update sequencer: ED, ack, value, ack.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      l_state      <= L_IDLE;
      timer        <= '0;
      the_command  <= 8'h00;
      send_command <= 1'b0;
      led_error    <= 1'b0;
      led_pending  <= 1'b0;
    end else begin
      case (l_state)
        L_IDLE: begin
          if (led_pending) begin
            led_pending  <= 1'b0;
            l_state      <= L_SEND_ED;
            the_command  <= 8'hED;
            send_command <= 1'b1;
          end
        end
        L_SEND_ED, L_SEND_VAL: begin
          if (bus.error_communication_timed_out) begin
            led_error    <= 1'b1;
            send_command <= 1'b0;
            l_state      <= L_IDLE;
          end else if (bus.command_was_sent) begin
            send_command <= 1'b0;
            timer        <= '0;
            l_state      <= (l_state == L_SEND_ED) ? L_ACK1 : L_ACK2;
          end
        end
        L_ACK1, L_ACK2: begin
          if (ack_seen) begin
            if (l_state == L_ACK1) begin
              l_state      <= L_SEND_VAL;
              the_command  <= {5'b0, caps_lock, 2'b0};
              send_command <= 1'b1;
            end else begin
              l_state <= L_IDLE;
            end
          end else if (timer == TW'(ACK_TIMEOUT - 1)) begin
            led_error <= 1'b1;
            l_state   <= L_IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: l_state <= L_IDLE;
      endcase
      // A toggle arriving while busy queues one more update with the latest value.
      if (caps_toggle) led_pending <= 1'b1;
    end
  end

  assign bus.key_code     = key_code;
  assign bus.key_extended = key_extended;
  assign bus.key_released = key_released;
  assign bus.key_ascii    = key_ascii;
  assign bus.key_valid    = key_valid;
  assign bus.shift_state  = shift_state;
  assign bus.caps_lock    = caps_lock;
  assign bus.overflow     = overflow;
  assign bus.the_command  = the_command;
  assign bus.send_command = send_command;
  assign bus.led_error    = led_error;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder with hand-computed expectations.
module tb_ps2_scancode_decoder;
  localparam int ACK_TO = 20;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   acc_cnt = 0;
  int   snap;

  ps2_scancode_decoder_if bus ();

  ps2_scancode_decoder #(.ACK_TIMEOUT(ACK_TO)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  // Count accepted events (valid & ready) between edges.
  always @(negedge clk)
    if (reset_n && bus.key_valid && bus.key_ready) acc_cnt <= acc_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.received_data    = b;
    bus.received_data_en = 1'b1;
    @(negedge clk);
    bus.received_data_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_send(input string tag);
    for (int i = 0; i < 50; i++) begin
      if (bus.send_command) break;
      @(negedge clk);
    end
    check(tag, bus.send_command, 1);
  endtask

  task automatic cmd_done();
    @(negedge clk);
    bus.command_was_sent = 1'b1;
    @(negedge clk);
    bus.command_was_sent = 1'b0;
  endtask

  task automatic check_event(input string tag, input logic [7:0] code, input logic ext,
                             input logic rel, input logic [7:0] asc);
    check({tag, "_valid"}, bus.key_valid, 1);
    check({tag, "_code"},  bus.key_code, code);
    check({tag, "_ext"},   bus.key_extended, ext);
    check({tag, "_rel"},   bus.key_released, rel);
    check({tag, "_ascii"}, bus.key_ascii, asc);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_valid"}, bus.key_valid, 0);
    check({tag, "_code"},  bus.key_code, 0);
    check({tag, "_ascii"}, bus.key_ascii, 0);
    check({tag, "_shift"}, bus.shift_state, 0);
    check({tag, "_caps"},  bus.caps_lock, 0);
    check({tag, "_ovf"},   bus.overflow, 0);
    check({tag, "_cmd"},   bus.the_command, 0);
    check({tag, "_send"},  bus.send_command, 0);
    check({tag, "_lederr"}, bus.led_error, 0);
  endtask

  initial begin
    bus.received_data = 8'h00;
    bus.received_data_en = 1'b0;
    bus.key_ready = 1'b1;
    bus.command_was_sent = 1'b0;
    bus.error_communication_timed_out = 1'b0;
    idle(3);
    check_reset("rst");
    reset_n = 1'b1;
    idle(2);

    // Plain make / break of 'a'
    send_byte(8'h1C);
    check_event("a_make", 8'h1C, 0, 0, 8'h61);
    send_byte(8'hF0); send_byte(8'h1C);
    check_event("a_break", 8'h1C, 0, 1, 8'h61);
    idle(2);
    check("a_pulses", acc_cnt, 2);

    // Shift
    send_byte(8'h12);
    check_event("lshift", 8'h12, 0, 0, 8'h00);
    check("shift_on", bus.shift_state, 1);
    send_byte(8'h1C);
    check_event("A_shift", 8'h1C, 0, 0, 8'h41);
    send_byte(8'h16);
    check("excl", bus.key_ascii, 8'h21);
    send_byte(8'hF0); send_byte(8'h12);
    check("shift_off", bus.shift_state, 0);
    send_byte(8'h1C);
    check("a_after", bus.key_ascii, 8'h61);
    send_byte(8'h29);
    check("space", bus.key_ascii, 8'h20);

    // Extended keys and fake shift
    send_byte(8'hE0); send_byte(8'h75);
    check_event("up_make", 8'h75, 1, 0, 8'h00);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    check_event("up_break", 8'h75, 1, 1, 8'h00);
    idle(1);
    snap = acc_cnt;
    send_byte(8'hE0); send_byte(8'h12);
    check("fake_valid", bus.key_valid, 0);
    idle(1);
    check("fake_cnt", acc_cnt, snap);
    check("fake_shift", bus.shift_state, 0);

    // Caps Lock with LED update
    send_byte(8'h58);
    check("caps_on", bus.caps_lock, 1);
    send_byte(8'h58);
    check("caps_rpt", bus.caps_lock, 1);
    send_byte(8'hF0); send_byte(8'h58);
    check("caps_brk", bus.caps_lock, 1);
    wait_send("ed_send");
    check("ed_cmd", bus.the_command, 8'hED);
    cmd_done();
    check("ed_drop", bus.send_command, 0);
    send_byte(8'hFA);
    wait_send("val_send");
    check("val_cmd", bus.the_command, 8'h04);
    cmd_done();
    send_byte(8'hFA);
    idle(ACK_TO + 5);
    check("led_ok_send", bus.send_command, 0);
    check("led_ok_err", bus.led_error, 0);
    send_byte(8'h1C);
    check("A_caps", bus.key_ascii, 8'h41);
    send_byte(8'h12); send_byte(8'h1C);
    check("a_caps_shift", bus.key_ascii, 8'h61);
    send_byte(8'hF0); send_byte(8'h12);
    send_byte(8'h16);
    check("one_caps", bus.key_ascii, 8'h31);

    // Caps off, LED ACK never arrives
    send_byte(8'h58); send_byte(8'hF0); send_byte(8'h58);
    check("caps_off", bus.caps_lock, 0);
    wait_send("ed2_send");
    check("ed2_cmd", bus.the_command, 8'hED);
    cmd_done();
    check("to_early", bus.led_error, 0);
    idle(ACK_TO + 10);
    check("to_err", bus.led_error, 1);
    check("to_send", bus.send_command, 0);

    // Overflow
    idle(2);
    bus.key_ready = 1'b0;
    send_byte(8'h1C);
    send_byte(8'h32);
    check_event("ovf_hold", 8'h1C, 0, 0, 8'h61);
    check("ovf_flag", bus.overflow, 1);
    bus.key_ready = 1'b1;
    idle(2);
    check("ovf_drain", bus.key_valid, 0);

    // Pause sequence
    snap = acc_cnt;
    send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
    send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0);
    check("pause_mid", bus.key_valid, 0);
    send_byte(8'h77);
    check_event("pause", 8'h77, 1, 0, 8'h00);
    idle(2);
    check("pause_cnt", acc_cnt, snap + 1);

    // Reset mid-pause
    send_byte(8'hE1); send_byte(8'h14);
    @(negedge clk); reset_n = 1'b0;
    idle(2);
    check_reset("rst2");
    reset_n = 1'b1;
    idle(1);
    send_byte(8'h1C);
    check_event("post_rst", 8'h1C, 0, 0, 8'h61);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
